lsu_mem_master: RTL and testbench

Load/store unit that sits between the pipeline MEM stage and the data-memory port, acting as the bus initiator. It accepts one load or store at a time from the pipeline and converts RISC-V byte/half/word semantics into word-aligned bus cycles with byte enables and lane-replicated write data. On loads it extracts and sign- or zero-extends the returned lane. It tolerates variable memory latency through a grant/rvalid handshake, and a cycle timeout stops a hung memory from locking the pipeline.

---
 rtl/lsu_mem_master.sv | 163 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store bus initiator: byte/half/word alignment, lane replication, load extension, grant timeout.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned halfword/word accesses without a bus cycle.
module lsu_mem_master #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [1:0]  state;
    logic [7:0]  tmo_cnt;
    logic [2:0]  func3_q;
    logic [1:0]  off_q;
    logic        acc;
    logic        acc_err;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext_data;
    logic        tmo_hit;

    // Request decode: byte enables, replicated store data, and whether a bus cycle is skipped.
    always_comb begin
        acc       = req_valid && req_ready;
        acc_err   = 1'b0;
        acc_be    = 4'b1111;
        acc_wdata = req_wdata;
        if (req_write) begin
            case (req_func3)
                3'b000: begin
                    acc_be    = 4'b0001 << req_addr[1:0];
                    acc_wdata = {4{req_wdata[7:0]}};
                end
                3'b001: begin
                    acc_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                    acc_wdata = {2{req_wdata[15:0]}};
                end
                3'b010:  acc_be = 4'b1111;
                default: acc_err = 1'b1;
            endcase
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_func3[1:0] == 2'b01 && req_addr[0]) acc_err = 1'b1;
        if (req_func3[1] && req_addr[1:0] != 2'b00) acc_err = 1'b1;
`endif
    end

    // Load lane selection and extension from the latched funct3 and byte offset.
    always_comb begin
        lane_b  = mem_rdata[{off_q, 3'b000} +: 8];
        lane_h  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        tmo_hit = (tmo_cnt == TMO_LAST);
        case (func3_q)
            3'b000:  ext_data = {{24{lane_b[7]}}, lane_b};
            3'b100:  ext_data = {24'b0, lane_b};
            3'b001:  ext_data = {{16{lane_h[15]}}, lane_h};
            3'b101:  ext_data = {16'b0, lane_h};
            default: ext_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            tmo_cnt   <= 8'd0;
            func3_q   <= 3'b0;
            off_q     <= 2'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'b0;
            rsp_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'b0;
            mem_be    <= 4'b0;
            mem_wdata <= 32'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'b0;
            case (state)
                S_IDLE: begin
                    if (acc) begin
                        req_ready <= 1'b0;
                        tmo_cnt   <= 8'd0;
                        func3_q   <= req_func3;
                        off_q     <= req_addr[1:0];
                        if (acc_err) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state     <= S_ADDR;
                            mem_req   <= 1'b1;
                            mem_we    <= req_write;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= acc_be;
                            mem_wdata <= acc_wdata;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_ADDR: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else if (tmo_hit) begin
                        mem_req   <= 1'b0;
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (mem_rvalid) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= ext_data;
                    end else if (tmo_hit) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master; a second instance with TIMEOUT_CYC = 8 covers the hung-memory case.
module tb_lsu_mem_master;
    logic        clk;
    logic        reset;
    logic        req_valid, req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        req_ready, rsp_valid, rsp_err, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        to_req_valid, to_gnt, to_rvalid;
    logic        to_req_ready, to_rsp_valid, to_rsp_err, to_mem_req, to_mem_we;
    logic [31:0] to_rsp_rdata, to_mem_addr, to_mem_wdata;
    logic [3:0]  to_mem_be;
    int          n_checks;
    int          n_fail;

    lsu_mem_master #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_mem_master #(.TIMEOUT_CYC(8)) dut_to (
        .clk(clk), .reset(reset), .req_valid(to_req_valid), .req_ready(to_req_ready),
        .req_write(req_write), .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(to_rsp_valid), .rsp_rdata(to_rsp_rdata), .rsp_err(to_rsp_err),
        .mem_req(to_mem_req), .mem_we(to_mem_we), .mem_addr(to_mem_addr), .mem_be(to_mem_be),
        .mem_wdata(to_mem_wdata), .mem_gnt(to_gnt), .mem_rvalid(to_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) tick();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wait_ready got=%b exp=1", req_ready); end
    endtask

    // Accepts a request in cycle 0 and returns at the start of cycle 1.
    task automatic start_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        wait_ready();
        req_valid = 1'b1; req_write = w; req_func3 = f3; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
        n_checks++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl got=%b%b exp=00", mem_req, rsp_valid); end
        n_checks++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_data got=%h/%h/%h exp=0", mem_addr, mem_be, rsp_rdata); end
        reset = 1'b0;
        tick(); tick();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got=%b exp=1", req_ready); end
    endtask

    task automatic test_store(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_wd);
        start_req(1'b1, f3, a, d);
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL %s_req got=%b%b exp=11", nm, mem_req, mem_we); end
        n_checks++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL %s_addr got=%h exp=%h", nm, mem_addr, exp_addr); end
        n_checks++; if (mem_be !== exp_be) begin n_fail++; $display("FAIL %s_be got=%b exp=%b", nm, mem_be, exp_be); end
        n_checks++; if (mem_wdata !== exp_wd) begin n_fail++; $display("FAIL %s_wdata got=%h exp=%h", nm, mem_wdata, exp_wd); end
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL %s_c1 got=%b%b exp=00", nm, rsp_valid, req_ready); end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL %s_rsp got=%b%b exp=10", nm, rsp_valid, rsp_err); end
        n_checks++; if (mem_req !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL %s_c2 got=%b/%h exp=0/0", nm, mem_req, rsp_rdata); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL %s_c3 got=%b%b exp=01", nm, rsp_valid, req_ready); end
    endtask

    // Grant in cycle 1, rvalid gap cycles after grant.
    task automatic test_load(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                             input int gap, input logic [31:0] exp_data);
        start_req(1'b0, f3, a, 32'h0);
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b1111) begin n_fail++; $display("FAIL %s_req got=%b%b%b exp=101111", nm, mem_req, mem_we, mem_be); end
        n_checks++; if (mem_addr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL %s_addr got=%h exp=%h", nm, mem_addr, {a[31:2], 2'b00}); end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL %s_req_drop got=%b exp=0", nm, mem_req); end
        for (int i = 1; i < gap; i++) begin
            n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early got=%b exp=0", nm, rsp_valid); end
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = rd;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL %s_rsp got=%b%b exp=10", nm, rsp_valid, rsp_err); end
        n_checks++; if (rsp_rdata !== exp_data) begin n_fail++; $display("FAIL %s_data got=%h exp=%h", nm, rsp_rdata, exp_data); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL %s_end got=%b%b exp=01", nm, rsp_valid, req_ready); end
    endtask

    task automatic test_wait_grant();
        int pulses;
        pulses = 0;
        start_req(1'b0, 3'b010, 32'h300, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_be !== 4'b1111) begin n_fail++; $display("FAIL wg_hold c%0d got=%b/%h/%b exp=1/300/1111", c, mem_req, mem_addr, mem_be); end
            n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL wg_ready c%0d got=%b exp=0", c, req_ready); end
            if (rsp_valid === 1'b1) pulses++;
            tick();
        end
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL wg_req_c6 got=%b exp=1", mem_req); end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int c = 7; c <= 8; c++) begin
            n_checks++; if (mem_req !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL wg_wait c%0d got=%b%b exp=00", c, mem_req, req_ready); end
            if (rsp_valid === 1'b1) pulses++;
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        n_checks++; if (rsp_rdata !== 32'hCAFE_F00D || req_ready !== 1'b0) begin n_fail++; $display("FAIL wg_data got=%h/%b exp=cafef00d/0", rsp_rdata, req_ready); end
        if (rsp_valid === 1'b1) pulses++;
        tick();
        if (rsp_valid === 1'b1) pulses++;
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL wg_pulses got=%0d exp=1", pulses); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wg_ready_end got=%b exp=1", req_ready); end
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 20 && to_req_ready !== 1'b1; i++) tick();
        to_req_valid = 1'b1; req_write = 1'b0; req_func3 = 3'b010; req_addr = 32'h500;
        tick();
        to_req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            n_checks++; if (to_mem_req !== 1'b1 || to_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_hold c%0d got=%b%b exp=10", c, to_mem_req, to_rsp_valid); end
            tick();
        end
        n_checks++; if (to_mem_req !== 1'b0) begin n_fail++; $display("FAIL to_req_drop got=%b exp=0", to_mem_req); end
        n_checks++; if (to_rsp_valid !== 1'b1 || to_rsp_err !== 1'b1) begin n_fail++; $display("FAIL to_rsp got=%b%b exp=11", to_rsp_valid, to_rsp_err); end
        n_checks++; if (to_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata got=%h exp=0", to_rsp_rdata); end
        tick();
        to_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            tick();
            to_rvalid = 1'b0;
            if (to_rsp_valid === 1'b1) pulses++;
        end
        mem_rdata = 32'h0;
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL to_late_rvalid got=%0d exp=0", pulses); end
        n_checks++; if (to_req_ready !== 1'b1) begin n_fail++; $display("FAIL to_ready_end got=%b exp=1", to_req_ready); end
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
        start_req(1'b1, 3'b010, 32'h202, 32'h1122_3344);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rsp got=%b%b/%h exp=11/0", rsp_valid, rsp_err, rsp_rdata); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_noreq got=%b exp=0", mem_req); end
        tick();
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mis_end got=%b%b exp=10", req_ready, rsp_valid); end
        start_req(1'b0, 3'b101, 32'h207, 32'h0);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_lhu got=%b%b%b exp=110", rsp_valid, rsp_err, mem_req); end
        tick();
`else
        test_store("sw_mis", 3'b010, 32'h202, 32'h1122_3344, 32'h200, 4'b1111, 32'h1122_3344);
        test_load("lhu_mis", 3'b101, 32'h207, 32'hBEEF_0000, 1, 32'h0000_BEEF);
`endif
    endtask

    task automatic test_illegal_store();
        logic [2:0] bad_f3 [2];
        bad_f3[0] = 3'b011;
        bad_f3[1] = 3'b100;
        for (int i = 0; i < 2; i++) begin
            start_req(1'b1, bad_f3[i], 32'h600, 32'hFFFF_FFFF);
            n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL ill_rsp f3=%b got=%b%b exp=11", bad_f3[i], rsp_valid, rsp_err); end
            n_checks++; if (mem_req !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL ill_nobus f3=%b got=%b/%h exp=0/0", bad_f3[i], mem_req, rsp_rdata); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_func3 = 3'b110; req_addr = 32'h700;
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_c1 got=%b%b exp=10", rsp_valid, req_ready); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_c2 got=%b%b exp=01", rsp_valid, req_ready); end
        tick();
        req_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL b2b_c3 got=%b%b exp=11", rsp_valid, rsp_err); end
        tick();
    endtask

    task automatic test_reset_mid();
        start_req(1'b0, 3'b010, 32'h400, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        reset = 1'b1;
        tick();
        n_checks++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL rm_clear got=%b%b%b exp=000", mem_req, rsp_valid, req_ready); end
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_AAAA;
        tick();
        mem_rvalid = 1'b0;
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_ready got=%b%b exp=10", req_ready, rsp_valid); end
        test_load("rm_lw", 3'b010, 32'h404, 32'h55AA_33CC, 1, 32'h55AA_33CC);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_func3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        to_req_valid = 1'b0; to_gnt = 1'b0; to_rvalid = 1'b0;
        test_reset();
        test_store("sb", 3'b000, 32'h103, 32'h0000_00A5, 32'h100, 4'b1000, 32'hA5A5_A5A5);
        test_store("sh", 3'b001, 32'h106, 32'h1234_BEEF, 32'h104, 4'b1100, 32'hBEEF_BEEF);
        test_load("lb", 3'b000, 32'h101, 32'h1234_8000, 2, 32'hFFFF_FF80);
        test_load("lbu", 3'b100, 32'h101, 32'h1234_8000, 2, 32'h0000_0080);
        test_load("lhu", 3'b101, 32'h102, 32'hBEEF_0000, 2, 32'h0000_BEEF);
        test_load("lh", 3'b001, 32'h102, 32'h8001_7FFF, 1, 32'hFFFF_8001);
        test_load("lw_min", 3'b010, 32'h10C, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
        test_wait_grant();
        test_timeout();
        test_misalign();
        test_illegal_store();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
